// File: rtl/dff_delay_line.sv
// Purpose : WIDTH-bit, DEPTH-stage delay line carrying a valid bit per stage, with stall, flush and a mid-chain tap.
// Latency : D/D_VALID reach Q/Q_VALID after exactly DEPTH enabled clock edges; stalled cycles do not count.
// Backpressure: EN=0 freezes every stage; there is no upstream ready, so the producer must hold or drop while stalled.
module dff_delay_line #(
    parameter int               WIDTH = 8,
    parameter int               DEPTH = 4,
    parameter logic [WIDTH-1:0] INIT  = '0,
    localparam int              SW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int              CW    = $clog2(DEPTH + 1)
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             EN,
    input  logic             CLR,
    input  logic [WIDTH-1:0] D,
    input  logic             D_VALID,
    input  logic [SW-1:0]    SEL,
    output logic [WIDTH-1:0] Q,
    output logic             Q_VALID,
    output logic [WIDTH-1:0] TAP,
    output logic             TAP_VALID,
    output logic [CW-1:0]    COUNT,
    output logic             FULL
);

    logic [WIDTH-1:0] s_q [DEPTH];
    logic [WIDTH-1:0] s_d [DEPTH];
    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;

    // Next state: flush beats shift; a flush cycle captures nothing from D.
    always_comb begin
        s_d = s_q;
        v_d = v_q;
        if (CLR) begin
            for (int i = 0; i < DEPTH; i++) begin
                s_d[i] = INIT;
                v_d[i] = 1'b0;
            end
        end else if (EN) begin
            s_d[0] = D;
            v_d[0] = D_VALID;
            for (int i = 1; i < DEPTH; i++) begin
                s_d[i] = s_q[i-1];
                v_d[i] = v_q[i-1];
            end
        end
    end

    // Stage registers with synchronous reset taking priority over everything.
    always_ff @(posedge CK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                s_q[i] <= INIT;
            end
            v_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                s_q[i] <= s_d[i];
            end
            v_q <= v_d;
        end
    end

    // Tap mux; a SEL beyond the last stage (non power-of-2 DEPTH) reads as an empty INIT stage.
    always_comb begin
        TAP       = INIT;
        TAP_VALID = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (SEL == SW'(i)) begin
                TAP       = s_q[i];
                TAP_VALID = v_q[i];
            end
        end
    end

    // Occupancy: population count of the valid bits.
    always_comb begin
        COUNT = '0;
        for (int i = 0; i < DEPTH; i++) begin
            COUNT = COUNT + CW'(v_q[i]);
        end
    end

    assign Q       = s_q[DEPTH-1];
    assign Q_VALID = v_q[DEPTH-1];
    assign FULL    = (COUNT == CW'(DEPTH));

endmodule

// File: tb/tb_dff_delay_line.sv
// Purpose : directed checks of dff_delay_line: a DEPTH=4/INIT=00 chain and a DEPTH=3/INIT=5A chain sharing stimulus.
// Latency : expected values are hand-derived per edge; inputs change 1 time unit after the rising edge and are checked there.
// Backpressure: EN is exercised directly as the stall control.
module tb_dff_delay_line;

    logic       clk = 1'b0;
    logic       rst, en, clr, dv;
    logic [7:0] d;
    logic [1:0] sel;
    logic [1:0] sel2;
    logic [7:0] q, tap, q2, tap2;
    logic       qv, tapv, full, qv2, tapv2, full2;
    logic [2:0] count;
    logic [1:0] count2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dff_delay_line #(.WIDTH(8), .DEPTH(4), .INIT(8'h00)) dut (
        .CK(clk), .RST(rst), .EN(en), .CLR(clr), .D(d), .D_VALID(dv), .SEL(sel),
        .Q(q), .Q_VALID(qv), .TAP(tap), .TAP_VALID(tapv), .COUNT(count), .FULL(full)
    );

    dff_delay_line #(.WIDTH(8), .DEPTH(3), .INIT(8'h5A)) dut3 (
        .CK(clk), .RST(rst), .EN(en), .CLR(clr), .D(d), .D_VALID(dv), .SEL(sel2),
        .Q(q2), .Q_VALID(qv2), .TAP(tap2), .TAP_VALID(tapv2), .COUNT(count2), .FULL(full2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] data, input logic valid);
        d = data; dv = valid; en = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; en = 1'($urandom); d = 8'($urandom); dv = 1'b1; sel = 2'd0; sel2 = 2'd3;
        step();
        rst = 1'b0; en = 1'b0;
        n_cmp++; if (q !== 8'h00)     begin n_bad++; $display("FAIL reset_q got %h exp 00", q); end
        n_cmp++; if (qv !== 1'b0)     begin n_bad++; $display("FAIL reset_qv got %b exp 0", qv); end
        n_cmp++; if (count !== 3'd0)  begin n_bad++; $display("FAIL reset_count got %0d exp 0", count); end
        n_cmp++; if (full !== 1'b0)   begin n_bad++; $display("FAIL reset_full got %b exp 0", full); end
        n_cmp++; if ({tap, tapv} !== {8'h00, 1'b0}) begin n_bad++; $display("FAIL reset_tap got %h/%b exp 00/0", tap, tapv); end
        n_cmp++; if (q2 !== 8'h5A)    begin n_bad++; $display("FAIL reset_init_q got %h exp 5a", q2); end
        n_cmp++; if ({tap2, tapv2} !== {8'h5A, 1'b0}) begin n_bad++; $display("FAIL reset_oor_tap got %h/%b exp 5a/0", tap2, tapv2); end
    endtask

    task automatic test_latency();
        logic [7:0] ins [7];
        logic [7:0] exp4;
        ins[0] = 8'h11; ins[1] = 8'h22; ins[2] = 8'h33; ins[3] = 8'h44;
        ins[4] = 8'h55; ins[5] = 8'h66; ins[6] = 8'h77;
        for (int i = 0; i < 7; i++) begin
            push(ins[i], 1'b1);
            if (i < 3) begin
                n_cmp++; if (qv !== 1'b0) begin n_bad++; $display("FAIL lat_early_qv edge %0d got %b exp 0", i + 1, qv); end
            end else begin
                exp4 = ins[i-3];
                n_cmp++; if ({q, qv} !== {exp4, 1'b1}) begin n_bad++; $display("FAIL lat_q edge %0d got %h/%b exp %h/1", i + 1, q, qv, exp4); end
                n_cmp++; if ({count, full} !== {3'd4, 1'b1}) begin n_bad++; $display("FAIL lat_count edge %0d got %0d/%b exp 4/1", i + 1, count, full); end
            end
            if (i == 2) begin
                n_cmp++; if ({q2, qv2, full2} !== {8'h11, 1'b1, 1'b1}) begin n_bad++; $display("FAIL lat_d3_q got %h/%b/%b exp 11/1/1", q2, qv2, full2); end
            end
            if (i == 3) begin
                sel = 2'd0; #1;
                n_cmp++; if ({tap, tapv} !== {8'h44, 1'b1}) begin n_bad++; $display("FAIL lat_tap0 got %h/%b exp 44/1", tap, tapv); end
                sel = 2'd2; #1;
                n_cmp++; if ({tap, tapv} !== {8'h22, 1'b1}) begin n_bad++; $display("FAIL lat_tap2 got %h/%b exp 22/1", tap, tapv); end
                n_cmp++; if ({tap2, tapv2} !== {8'h5A, 1'b0}) begin n_bad++; $display("FAIL lat_oor_tap got %h/%b exp 5a/0", tap2, tapv2); end
            end
        end
        en = 1'b0;
    endtask

    task automatic test_stall();
        clr = 1'b1; step(); clr = 1'b0;
        push(8'hAA, 1'b1);
        push(8'hBB, 1'b1);
        en = 1'b0; d = 8'hCC; dv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if ({count, qv} !== {3'd2, 1'b0}) begin n_bad++; $display("FAIL stall_hold cycle %0d got %0d/%b exp 2/0", i, count, qv); end
        end
        sel = 2'd0; #1;
        n_cmp++; if ({tap, tapv} !== {8'hBB, 1'b1}) begin n_bad++; $display("FAIL stall_tap0 got %h/%b exp bb/1", tap, tapv); end
        sel = 2'd1; #1;
        n_cmp++; if ({tap, tapv} !== {8'hAA, 1'b1}) begin n_bad++; $display("FAIL stall_tap1 got %h/%b exp aa/1", tap, tapv); end
        push(8'h00, 1'b0);
        n_cmp++; if (qv !== 1'b0) begin n_bad++; $display("FAIL resume_early got %b exp 0", qv); end
        push(8'h00, 1'b0);
        n_cmp++; if ({q, qv} !== {8'hAA, 1'b1}) begin n_bad++; $display("FAIL resume_q got %h/%b exp aa/1", q, qv); end
        n_cmp++; if ({count, full} !== {3'd2, 1'b0}) begin n_bad++; $display("FAIL resume_count got %0d/%b exp 2/0", count, full); end
        en = 1'b0;
    endtask

    task automatic test_bubbles();
        clr = 1'b1; step(); clr = 1'b0;
        push(8'h01, 1'b1);
        push(8'hEE, 1'b0);
        push(8'h03, 1'b1);
        en = 1'b0;
        sel = 2'd1; #1;
        n_cmp++; if ({tap, tapv} !== {8'hEE, 1'b0}) begin n_bad++; $display("FAIL bubble_tap1 got %h/%b exp ee/0", tap, tapv); end
        sel = 2'd2; #1;
        n_cmp++; if ({tap, tapv} !== {8'h01, 1'b1}) begin n_bad++; $display("FAIL bubble_tap2 got %h/%b exp 01/1", tap, tapv); end
        n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL bubble_count got %0d exp 2", count); end
        n_cmp++; if ({count2, qv2} !== {2'd2, 1'b1}) begin n_bad++; $display("FAIL bubble_d3 got %0d/%b exp 2/1", count2, qv2); end
    endtask

    task automatic test_flush_priority();
        push(8'hA1, 1'b1); push(8'hA2, 1'b1); push(8'hA3, 1'b1); push(8'hA4, 1'b1);
        n_cmp++; if ({count, full} !== {3'd4, 1'b1}) begin n_bad++; $display("FAIL flush_prefill got %0d/%b exp 4/1", count, full); end
        clr = 1'b1; en = 1'b1; d = 8'hFF; dv = 1'b1;
        step();
        clr = 1'b0;
        n_cmp++; if ({q, qv, count, full} !== {8'h00, 1'b0, 3'd0, 1'b0}) begin n_bad++; $display("FAIL flush_state got %h/%b/%0d/%b exp 00/0/0/0", q, qv, count, full); end
        n_cmp++; if ({q2, count2} !== {8'h5A, 2'd0}) begin n_bad++; $display("FAIL flush_d3 got %h/%0d exp 5a/0", q2, count2); end
        for (int i = 0; i < 4; i++) begin
            push(8'h00, 1'b0);
            n_cmp++; if ({q, qv} !== {8'h00, 1'b0}) begin n_bad++; $display("FAIL flush_no_ff edge %0d got %h/%b exp 00/0", i + 1, q, qv); end
        end
        en = 1'b0;
    endtask

    task automatic test_stall_vs_flush_reset();
        push(8'h42, 1'b1);
        en = 1'b0; rst = 1'b1; clr = 1'b0;
        step();
        rst = 1'b0;
        n_cmp++; if ({count, tap2, tapv2, q2} !== {3'd0, 8'h5A, 1'b0, 8'h5A}) begin n_bad++; $display("FAIL rst_midstream got %0d/%h/%b/%h exp 0/5a/0/5a", count, tap2, tapv2, q2); end
        push(8'h99, 1'b1); push(8'h00, 1'b0); push(8'h00, 1'b0);
        n_cmp++; if ({q2, qv2} !== {8'h99, 1'b1}) begin n_bad++; $display("FAIL rst_fresh_latency got %h/%b exp 99/1", q2, qv2); end
        n_cmp++; if (qv !== 1'b0) begin n_bad++; $display("FAIL rst_fresh_d4_early got %b exp 0", qv); end
        push(8'h00, 1'b0);
        n_cmp++; if ({q, qv} !== {8'h99, 1'b1}) begin n_bad++; $display("FAIL rst_fresh_d4 got %h/%b exp 99/1", q, qv); end
        en = 1'b0;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; clr = 1'b0; dv = 1'b0; d = 8'h00; sel = 2'd0; sel2 = 2'd3;
        test_reset();
        test_latency();
        test_stall();
        test_bubbles();
        test_flush_priority();
        test_stall_vs_flush_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dff_delay_line.md
Name: dff_delay_line

Overview:
- Parametrised successor to the single-bit DFF: a WIDTH-bit, DEPTH-stage register chain with a per-stage valid bit.
- Supports stall (EN), synchronous flush (CLR), a selectable mid-chain tap and occupancy reporting.
- Used as the standard retiming/delay element wherever data and its qualifier must be delayed together by a fixed number of clocks.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 4, number of register stages (>=1); end-to-end latency in enabled cycles.
- INIT, 0, WIDTH-bit value loaded into every data stage on reset or flush.

Ports:
- CK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset, synchronous, active-high.
- EN  input  1  shift enable; 0 = stall, all stages hold.
- CLR  input  1  synchronous flush of all stages.
- D  input  WIDTH  data into stage 0.
- D_VALID  input  1  qualifier for D.
- SEL  input  max(1,$clog2(DEPTH))  tap stage index.
- Q  output  WIDTH  data of stage DEPTH-1.
- Q_VALID  output  1  valid of stage DEPTH-1.
- TAP  output  WIDTH  data of stage SEL.
- TAP_VALID  output  1  valid of stage SEL.
- COUNT  output  $clog2(DEPTH+1)  number of stages currently valid.
- FULL  output  1  1 when all DEPTH stages are valid.

Behaviour:
- State: data s[0..DEPTH-1] (WIDTH each), valid v[0..DEPTH-1]. Only RST and CLR touch the state asynchronously to data flow; both act at the clock edge.
- Priority at the rising CK edge is RST > CLR > EN.
- RST=1: every s[i]=INIT, every v[i]=0.
  - Outputs after reset: Q=INIT, Q_VALID=0, TAP=INIT, TAP_VALID=0, COUNT=0, FULL=0.
- CLR=1 (RST=0): same effect as reset, regardless of EN. D is not captured in that cycle.
- EN=1 (RST=0, CLR=0):
  - s[0]<=D, v[0]<=D_VALID.
  - s[i]<=s[i-1], v[i]<=v[i-1] for i=1..DEPTH-1.
  - The old stage DEPTH-1 content is discarded.
- EN=0 (RST=0, CLR=0): all stages hold; D and D_VALID are ignored.
- Latency: D is presented on Q exactly DEPTH enabled edges after capture. Stalled cycles add no shifts.
- DEPTH=1 degenerates to an enabled, clearable DFF with a valid bit. SEL is 1 bit in this case; SEL=0 selects stage 0.
- Invalid data still shifts (bubbles propagate). Data of invalid stages is not forced to INIT except by RST/CLR.
- Q, Q_VALID, TAP, TAP_VALID, COUNT and FULL are combinational from registered state plus SEL; none depend on D, EN or CLR in the same cycle.
- TAP/TAP_VALID = s[SEL]/v[SEL].
  - If SEL >= DEPTH (non-power-of-2 DEPTH): TAP=INIT, TAP_VALID=0.
- COUNT = popcount(v), range 0..DEPTH, no wrap.
- FULL = (COUNT==DEPTH).
- RST or CLR asserted mid-stream: all in-flight entries are lost on that edge. Data entering on the following enabled edge starts a fresh DEPTH-cycle latency.
- Simultaneous EN=1 and CLR=1: CLR wins and nothing is captured.

Test Plan (WIDTH=8, DEPTH=4, INIT=8'h00 unless stated):
- Reset: RST=1 for 1 edge with random D/EN -> Q=00, Q_VALID=0, COUNT=0, FULL=0.
- Latency: EN=1; D=11,22,33,44 with D_VALID=1 on 4 consecutive edges -> Q=11, Q_VALID=1 after 4th edge; FULL=1, COUNT=4; then 22,33,44 on next edges.
- Stall: after 2 valid inputs (AA,BB), hold EN=0 for 3 edges -> COUNT stays 2, Q_VALID=0. Resume EN=1 with D_VALID=0 -> AA appears on Q after 2 more edges.
- Bubbles/tap: inputs 01(valid), xx(invalid), 03(valid) -> with SEL=1 after 3rd edge TAP=xx, TAP_VALID=0; with SEL=2, TAP=01, TAP_VALID=1; COUNT=2.
- Flush priority: chain full; assert CLR=1 together with EN=1, D=FF, D_VALID=1 for one edge -> COUNT=0, Q=00. FF never appears on Q.
- Out-of-range tap and INIT: DEPTH=3, INIT=8'h5A, SEL=3 -> TAP=5A, TAP_VALID=0 always. After RST, Q=5A.
